// File: rtl/led_drv_pkg.sv
// Shared constants, channel-state type and width helpers for the LED status driver.
package led_drv_pkg;

  localparam int DEF_N_CH        = 8;
  localparam int DEF_HOLD_CYCLES = 1_000_000;
  localparam int DEF_PWM_BITS    = 4;
  localparam int DEF_CNT_BITS    = 8;

  typedef enum logic [1:0] {
    CH_DARK,
    CH_ACTIVE,
    CH_STRETCH
  } ch_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Never returns zero, so a degenerate parameter still yields a legal vector width.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One status channel: input registers, retriggerable hold stretcher and saturating edge counter.
module led_channel
  import led_drv_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_BITS    = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                status,
  input  logic                cnt_clr,
  output logic                lit,
  output logic [CNT_BITS-1:0] count
);

  localparam int                 HOLD_W    = width_of(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic              s_q;
  logic              s_q2;
  logic              rise;
  logic [HOLD_W-1:0] hold;
  ch_state_e         state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= 1'b0;
      s_q2 <= 1'b0;
    end else begin
      s_q  <= status;
      s_q2 <= s_q;
    end
  end

  assign rise = s_q & ~s_q2;

  // Reloads while the input is high, so back-to-back pulses never leave a dark gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (s_q) begin
      hold <= HOLD_LOAD;
    end else if (hold != '0) begin
      hold <= hold - HOLD_W'(1);
    end
  end

  // A clear coinciding with an edge keeps that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (cnt_clr) begin
      count <= rise ? CNT_BITS'(1) : '0;
    end else if (rise && (count != CNT_MAX)) begin
      count <= count + CNT_BITS'(1);
    end
  end

  always_comb begin
    state = CH_DARK;
    if (s_q) begin
      state = CH_ACTIVE;
    end else if (hold != '0) begin
      state = CH_STRETCH;
    end
  end

  assign lit = (state != CH_DARK);

  hold_in_range : assert property (@(posedge clk) disable iff (rst) hold <= HOLD_LOAD);

endmodule

// File: rtl/led_status_driver.sv
// Turns raw status bits into stretched, PWM-dimmed LED drives with per-channel edge counters.
module led_status_driver
  import led_drv_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int CNT_BITS    = DEF_CNT_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           status_in,
  input  logic [PWM_BITS-1:0]       duty,
  input  logic                      cnt_clr,
  input  logic [width_of(N_CH)-1:0] cnt_sel,
  output logic [N_CH-1:0]           led_out,
  output logic [CNT_BITS-1:0]       cnt_out
);

  localparam int SEL_W = width_of(N_CH);

  logic [N_CH-1:0]     lit;
  logic [CNT_BITS-1:0] count [N_CH];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [CNT_BITS-1:0] sel_count;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .CNT_BITS   (CNT_BITS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .status (status_in[i]),
      .cnt_clr(cnt_clr),
      .lit    (lit[i]),
      .count  (count[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // All-ones duty must be fully on, which a plain compare cannot reach.
  assign pwm_on = (pwm_cnt < duty) | (&duty);

  // Selects that match no channel fall through to zero.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        sel_count = count[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
      cnt_out <= '0;
    end else begin
      led_out <= lit & {N_CH{pwm_on}};
      cnt_out <= sel_count;
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_led_status_driver;

  localparam int N_CH     = 8;
  localparam int HOLD     = 4;
  localparam int PWM_BITS = 3;
  localparam int CNT_BITS = 8;
  localparam bit LED      = 1'b0;
  localparam bit CNT      = 1'b1;

  typedef struct {
    int         at;
    bit         kind;
    logic [7:0] mask;
    logic [7:0] value;
    string      name;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_CH-1:0]     status_in;
  logic [PWM_BITS-1:0] duty;
  logic                cnt_clr;
  logic [2:0]          cnt_sel;
  logic [N_CH-1:0]     led_out;
  logic [CNT_BITS-1:0] cnt_out;

  int   cyc     = 0;
  int   checks  = 0;
  int   fails   = 0;
  int   rel_cyc = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [7:0] mon_act;

  led_status_driver #(
    .N_CH       (N_CH),
    .HOLD_CYCLES(HOLD),
    .PWM_BITS   (PWM_BITS),
    .CNT_BITS   (CNT_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .status_in(status_in),
    .duty     (duty),
    .cnt_clr  (cnt_clr),
    .cnt_sel  (cnt_sel),
    .led_out  (led_out),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectations are tagged with the edge count after which the output must hold.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = (mon_e.kind == CNT) ? cnt_out : led_out;
      checks++;
      if (mon_e.at != cyc || (mon_act & mon_e.mask) != mon_e.value) begin
        fails++;
        $display("[TB] FAIL %s cyc=%0d due=%0d got=%h want=%h (mask %h)",
                 mon_e.name, cyc, mon_e.at, mon_act & mon_e.mask, mon_e.value, mon_e.mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input int at, input bit kind, input logic [7:0] mask,
                              input logic [7:0] value, input string name);
    exp_t e;
    int   idx;
    e.at    = at;
    e.kind  = kind;
    e.mask  = mask;
    e.value = value & mask;
    e.name  = name;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].at > at) begin
        idx = i;
        break;
      end
    end
    q.insert(idx, e);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int x;
    rst       = 1'b1;
    status_in = 8'hFF;
    duty      = 3'd7;
    cnt_clr   = 1'b0;
    cnt_sel   = 3'd0;

    repeat (3) tick();
    check_output(cyc, LED, 8'hFF, 8'h00, "reset_led");
    check_output(cyc, CNT, 8'hFF, 8'h00, "reset_cnt");
    tick();

    // Status still high at release counts as a fresh edge.
    rst     = 1'b0;
    rel_cyc = cyc;
    check_output(rel_cyc + 1, LED, 8'hFF, 8'h00, "release_led_first_edge");
    check_output(rel_cyc + 2, LED, 8'hFF, 8'hFF, "release_led_second_edge");
    check_output(rel_cyc + 3, CNT, 8'hFF, 8'h01, "release_rise_count");
    repeat (3) tick();
    status_in = 8'h00;
    repeat (8) tick();
    check_output(cyc + 1, LED, 8'hFF, 8'h00, "dark_after_drop");

    x       = cyc;
    cnt_clr = 1'b1;
    cnt_sel = 3'd3;
    check_output(x + 1, CNT, 8'hFF, 8'h01, "sel3_before_clr");
    check_output(x + 2, CNT, 8'hFF, 8'h00, "clr_alone_sel3");
    tick();
    cnt_clr = 1'b0;
    repeat (3) tick();

    k         = cyc;
    status_in = 8'h08;
    check_output(k + 1, LED, 8'h08, 8'h00, "pulse_before");
    for (int e = 2; e <= 5; e++) check_output(k + e, LED, 8'h08, 8'h08, "pulse_lit");
    check_output(k + 6, LED, 8'h08, 8'h00, "pulse_after");
    check_output(k + 3, CNT, 8'hFF, 8'h01, "pulse_count");
    tick();
    status_in = 8'h00;
    repeat (6) tick();

    k         = cyc;
    cnt_sel   = 3'd0;
    status_in = 8'h01;
    check_output(k + 1, LED, 8'h01, 8'h00, "retrig_before");
    for (int e = 2; e <= 7; e++) check_output(k + e, LED, 8'h01, 8'h01, "retrig_lit");
    check_output(k + 8, LED, 8'h01, 8'h00, "retrig_after");
    check_output(k + 5, CNT, 8'hFF, 8'h02, "retrig_count");
    tick();
    status_in = 8'h00;
    tick();
    status_in = 8'h01;
    tick();
    status_in = 8'h00;
    repeat (7) tick();

    // PWM counter phase is counted from the reset release.
    k         = cyc;
    status_in = 8'h02;
    duty      = 3'd4;
    for (int e = k + 2; e <= k + 17; e++) begin
      check_output(e, LED, 8'h02, (((e - 1 - rel_cyc) % 8) < 4) ? 8'h02 : 8'h00, "pwm_half");
    end
    repeat (18) tick();
    k    = cyc;
    duty = 3'd0;
    for (int e = k + 1; e <= k + 8; e++) check_output(e, LED, 8'h02, 8'h00, "pwm_zero");
    repeat (9) tick();
    status_in = 8'h00;
    duty      = 3'd7;
    repeat (6) tick();

    cnt_sel = 3'd7;
    for (int i = 0; i < 300; i++) begin
      status_in = 8'h80;
      tick();
      status_in = 8'h00;
      tick();
    end
    repeat (3) tick();
    check_output(cyc + 1, CNT, 8'hFF, 8'hFF, "saturate_255");
    repeat (2) tick();

    k         = cyc;
    status_in = 8'h80;
    check_output(k + 2, CNT, 8'hFF, 8'hFF, "before_clr_with_rise");
    check_output(k + 3, CNT, 8'hFF, 8'h01, "clr_with_rise");
    tick();
    cnt_clr   = 1'b1;
    status_in = 8'h00;
    tick();
    cnt_clr = 1'b0;
    repeat (3) tick();
    x       = cyc;
    cnt_clr = 1'b1;
    check_output(x + 1, CNT, 8'hFF, 8'h01, "before_clr_alone");
    check_output(x + 2, CNT, 8'hFF, 8'h00, "clr_alone_sel7");
    tick();
    cnt_clr = 1'b0;
    repeat (8) tick();

    k         = cyc;
    status_in = 8'h20;
    check_output(k + 2, LED, 8'h20, 8'h20, "stretch_lit");
    tick();
    status_in = 8'h00;
    repeat (2) tick();
    rst = 1'b1;
    check_output(cyc, LED, 8'hFF, 8'h00, "async_reset_blank");
    check_output(cyc, CNT, 8'hFF, 8'h00, "async_reset_cnt");
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) check_output(cyc + i, LED, 8'hFF, 8'h00, "dark_after_reset");
    repeat (8) tick();

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      fails += q.size();
      $display("[TB] FAIL undrained got=%0d pending want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_status_driver.md
# led_status_driver

Downstream stage for the 8-bit status bus produced by the demo top-level (counter MSBs, FSM-done flags, shift-register taps, memory bit). It turns raw status bits into LED drive signals that a person can see. Each channel is registered once. A short pulse is stretched to a minimum visible on-time, and the lit level is dimmed by a shared PWM. The block also keeps a saturating per-channel rising-edge count, selectable for debug readout.

## Interface
- `N_CH`, default 8: number of status/LED channels.
- `HOLD_CYCLES`, default 1_000_000: minimum lit duration in clk cycles after status drops. Legal range is ≥1; 1 means no stretch.
- `PWM_BITS`, default 4: width of the PWM counter and of `duty`.
- `CNT_BITS`, default 8: width of each saturating event counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `status_in`  in  N_CH  raw status bits, synchronous to clk.
- `duty`  in  PWM_BITS  brightness. 0 = off; all-ones = fully on.
- `cnt_clr`  in  1  single-cycle pulse; clears all event counters.
- `cnt_sel`  in  clog2(N_CH)  selects the channel for `cnt_out`.
- `led_out`  out  N_CH  registered LED drive.
- `cnt_out`  out  CNT_BITS  registered event count of the selected channel.

## Operation
- **Input registers.** Per channel, `s_q <= status_in[i]` and `s_q2 <= s_q`. A rising edge is `rise = s_q & ~s_q2`.
- **Hold counter** (width clog2(HOLD_CYCLES)):
  - Loaded with HOLD_CYCLES-1 on every cycle that `s_q` = 1 (retriggerable).
  - Otherwise decrements when nonzero; it never wraps below 0.
- **Channel state** (decoded, not stored):
  - DARK: `s_q` = 0 and hold = 0.
  - ACTIVE: `s_q` = 1.
  - STRETCH: `s_q` = 0 and hold ≠ 0.
  - `lit` = ACTIVE or STRETCH.
- **PWM:**
  - `pwm_cnt` is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
  - `pwm_on = (pwm_cnt < duty) | (&duty)`.
  - `duty` is sampled combinationally each cycle; changes take effect at the next compare.
- **LED output:** `led_out[i] <= lit & pwm_on`.
- **Event counter:**
  - Increments on `rise` and saturates at 2^CNT_BITS-1.
  - `cnt_clr` zeroes every counter.
  - If `cnt_clr` and `rise` occur in the same cycle, the counter becomes 1 (the edge is not lost).
- **Readout:** `cnt_out <= count[cnt_sel]`. An out-of-range `cnt_sel` (when N_CH is not a power of 2) yields 0.
- **Reset:**
  - `led_out` = 0 and `cnt_out` = 0.
  - `s_q`, `s_q2`, hold counters, `pwm_cnt` and event counters = 0.
  - An assertion mid-stretch blanks the LEDs immediately (asynchronously). After release, a status bit that is still high counts as a new rising edge.

## Timing
- Latency from `status_in` rising (sampled at edge k) to `led_out` rising is edge k+1, when `pwm_on` is true in cycle k.
- A single-cycle `status_in` pulse gives `lit` for exactly HOLD_CYCLES consecutive cycles.
- A status bit high for P cycles gives `lit` for P + HOLD_CYCLES - 1 cycles.
- A new pulse during STRETCH reloads the hold counter; there is no dark gap.
- An edge registers in the count one cycle after `s_q` rises. `cnt_out` follows one cycle after that, or one cycle after a `cnt_sel` change.
- PWM period is 2^PWM_BITS cycles. The lit fraction is duty/2^PWM_BITS, except all-ones, which gives 100%.
- There is no back-pressure or handshake; every input is consumed each cycle.

## Structure
- Package `led_drv_pkg` holds:
  - default parameter constants;
  - the channel-state enum (DARK/ACTIVE/STRETCH), used for assertions and debug;
  - a `clog2` helper function.
- Sub-module `led_channel` covers one channel: input registers, hold counter, event counter, and outputs `lit` and `count`.
- The top level instantiates N_CH channels and owns the PWM counter, output register and readout mux.

## Test plan
- **Reset:** assert `rst` with `status_in` = 8'hFF → `led_out` = 0 and `cnt_out` = 0 while in reset. After release, `led_out` = 8'hFF two edges later (duty = all-ones).
- **Single pulse:** HOLD_CYCLES=4, duty=4'hF, one-cycle pulse on bit 3 → `led_out[3]` high for exactly 4 cycles, starting edge k+1; `cnt_out` (sel=3) = 1.
- **Retrigger:** HOLD=4, pulses on bit 0 at cycles 0 and 2 → `led_out[0]` continuously high for 6 cycles with no gap; count = 2.
- **PWM:** PWM_BITS=3, duty=3'd4, status bit 1 held high → `led_out[1]` high 4 of every 8 cycles. duty=0 → always 0.
- **Saturation and clear:**
  - 300 pulses on bit 7 with CNT_BITS=8 → `cnt_out` = 255.
  - `cnt_clr` coincident with a rise → count = 1.
  - `cnt_clr` alone → count = 0.
- **Reset mid-stretch:** HOLD=100, pulse, then `rst` at cycle 10 → `led_out` = 0 immediately. After release with status low, the LED stays dark.
